// File: rtl/regfile_write_arbiter.sv
// ============================================================================
// Module  : regfile_write_arbiter
// Purpose : Shares the register-file write port between writeback (priority)
//           and a 2-entry auxiliary write FIFO. Define RFARB_STARVE_GUARD_EN
//           to enable the starvation guard (FORCE state, stall_req).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_write_arbiter
`ifdef RFARB_STARVE_GUARD_EN
  #(parameter int STARVE_LIMIT = 8)  // 1..15 consecutive blocked cycles
`endif
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       writeReg_w,
  input  logic [3:0] dst_w,
  input  logic [7:0] regData_w,
  input  logic       aux_valid,
  output logic       aux_ready,
  input  logic [3:0] aux_dst,
  input  logic [7:0] aux_data,
  output logic       rf_we,
  output logic [3:0] rf_addr,
  output logic [7:0] rf_wdata,
  output logic       stall_req
);

  logic [11:0] mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic [1:0]  count_nxt;
  logic        push;
  logic        pop;
  logic [11:0] head;

  // Full FIFO refuses pushes even when a pop frees a slot the same edge.
  assign aux_ready = (count != 2'd2);
  assign push      = aux_valid && aux_ready;
  assign pop       = !writeReg_w && (count != 2'd0);
  assign head      = mem[rd_ptr];
  assign count_nxt = count + {1'b0, push} - {1'b0, pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {aux_dst, aux_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_addr  <= 4'd0;
      rf_wdata <= 8'd0;
    end else begin
      rf_we <= writeReg_w | pop;
      if (writeReg_w) begin
        rf_addr  <= dst_w;
        rf_wdata <= regData_w;
      end else if (pop) begin
        {rf_addr, rf_wdata} <= head;
      end
    end
  end

`ifdef RFARB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] wait_cnt;

  // PEND always holds a non-empty FIFO, so writeback idle means a head grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      stall_req <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (push) begin
            state    <= PEND;
            wait_cnt <= 4'd0;
          end
        end
        PEND: begin
          if (writeReg_w) begin
            if (wait_cnt == LIMIT_M1) begin
              state     <= FORCE;
              stall_req <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 4'd1;
            end
          end else begin
            wait_cnt <= 4'd0;
            state    <= (count_nxt != 2'd0) ? PEND : IDLE;
          end
        end
        FORCE: begin
          if (!writeReg_w) begin
            wait_cnt  <= 4'd0;
            stall_req <= 1'b0;
            state     <= (count_nxt != 2'd0) ? PEND : IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          wait_cnt  <= 4'd0;
          stall_req <= 1'b0;
        end
      endcase
    end
  end
`else
  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (push) state <= PEND;
        PEND: if (!writeReg_w) state <= (count_nxt != 2'd0) ? PEND : IDLE;
      endcase
    end
  end

  assign stall_req = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
// ============================================================================
// Module  : tb_regfile_write_arbiter
// Purpose : Directed self-checking bench with a queue-based reference model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_write_arbiter;

  localparam int STARVE_LIMIT = 8;
`ifdef RFARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       writeReg_w = 1'b0;
  logic [3:0] dst_w = 4'd0;
  logic [7:0] regData_w = 8'd0;
  logic       aux_valid = 1'b0;
  logic       aux_ready;
  logic [3:0] aux_dst = 4'd0;
  logic [7:0] aux_data = 8'd0;
  logic       rf_we;
  logic [3:0] rf_addr;
  logic [7:0] rf_wdata;
  logic       stall_req;

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .writeReg_w (writeReg_w),
    .dst_w      (dst_w),
    .regData_w  (regData_w),
    .aux_valid  (aux_valid),
    .aux_ready  (aux_ready),
    .aux_dst    (aux_dst),
    .aux_data   (aux_data),
    .rf_we      (rf_we),
    .rf_addr    (rf_addr),
    .rf_wdata   (rf_wdata),
    .stall_req  (stall_req)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: pending aux writes as a queue, starvation as a plain
  // count of consecutive blocked edges since the last grant.
  logic [11:0] q [$];
  logic        m_we;
  logic [3:0]  m_addr;
  logic [7:0]  m_data;
  logic        m_stall;
  int          blocked;

  always @(posedge clk or negedge rst_n) begin : model
    int n;
    logic [11:0] e;
    if (!rst_n) begin
      q.delete();
      m_we = 1'b0; m_addr = 4'd0; m_data = 8'd0; m_stall = 1'b0; blocked = 0;
    end else begin
      n = q.size();
      if (writeReg_w) begin
        m_we = 1'b1; m_addr = dst_w; m_data = regData_w;
      end else if (n > 0) begin
        e = q.pop_front();
        m_we = 1'b1; m_addr = e[11:8]; m_data = e[7:0];
      end else begin
        m_we = 1'b0;
      end
      if (aux_valid && n != 2) q.push_back({aux_dst, aux_data});
      if (n > 0 && writeReg_w) blocked++;
      else blocked = 0;
      m_stall = GUARD && (blocked >= STARVE_LIMIT);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc_rf_we", int'(rf_we), int'(m_we));
      if (m_we) begin
        check("cyc_rf_addr", int'(rf_addr), int'(m_addr));
        check("cyc_rf_wdata", int'(rf_wdata), int'(m_data));
      end
      check("cyc_aux_ready", int'(aux_ready), int'(q.size() != 2));
      check("cyc_stall_req", int'(stall_req), int'(m_stall));
    end
  end

  task automatic cyc(input logic we, input logic [3:0] d, input logic [7:0] v,
                     input logic av, input logic [3:0] ad, input logic [7:0] avd);
    writeReg_w = we; dst_w = d; regData_w = v;
    aux_valid = av; aux_dst = ad; aux_data = avd;
    @(posedge clk); #1;
  endtask

  task automatic lit(input string name, input logic we, input logic [3:0] a,
                     input logic [7:0] d, input logic rdy, input logic st);
    check({name, "_we"}, int'(rf_we), int'(we));
    if (we) begin
      check({name, "_addr"}, int'(rf_addr), int'(a));
      check({name, "_data"}, int'(rf_wdata), int'(d));
    end
    check({name, "_ready"}, int'(aux_ready), int'(rdy));
    check({name, "_stall"}, int'(stall_req), int'(st));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr", int'(rf_addr), 0);
    check("rst_data", int'(rf_wdata), 0);
    lit("rst", 1'b0, 4'd0, 8'd0, 1'b1, 1'b0);
    rst_n = 1'b1;

    // Writeback only
    cyc(1, 4'd3, 8'hA5, 0, 4'd0, 8'd0);
    lit("wb_only", 1'b1, 4'd3, 8'hA5, 1'b1, 1'b0);
    cyc(0, 4'd0, 8'd0, 0, 4'd0, 8'd0);
    lit("wb_idle", 1'b0, 4'd0, 8'd0, 1'b1, 1'b0);

    // Aux path with writeback idle
    cyc(0, 4'd0, 8'd0, 1, 4'd5, 8'h3C);
    lit("aux_push", 1'b0, 4'd0, 8'd0, 1'b1, 1'b0);
    cyc(0, 4'd0, 8'd0, 0, 4'd0, 8'd0);
    lit("aux_write", 1'b1, 4'd5, 8'h3C, 1'b1, 1'b0);
    cyc(0, 4'd0, 8'd0, 0, 4'd0, 8'd0);

    // Collision and full FIFO
    cyc(1, 4'd8, 8'h80, 1, 4'd1, 8'h11);
    lit("full_1", 1'b1, 4'd8, 8'h80, 1'b1, 1'b0);
    cyc(1, 4'd9, 8'h90, 1, 4'd2, 8'h22);
    lit("full_2", 1'b1, 4'd9, 8'h90, 1'b0, 1'b0);
    cyc(1, 4'd10, 8'hA0, 1, 4'd3, 8'h33);
    lit("full_3", 1'b1, 4'd10, 8'hA0, 1'b0, 1'b0);
    cyc(0, 4'd0, 8'd0, 0, 4'd0, 8'd0);
    lit("drain_1", 1'b1, 4'd1, 8'h11, 1'b1, 1'b0);
    cyc(0, 4'd0, 8'd0, 0, 4'd0, 8'd0);
    lit("drain_2", 1'b1, 4'd2, 8'h22, 1'b1, 1'b0);
    cyc(0, 4'd0, 8'd0, 0, 4'd0, 8'd0);
    lit("drain_end", 1'b0, 4'd0, 8'd0, 1'b1, 1'b0);

    // Same destination, pipeline first then aux
    cyc(1, 4'd7, 8'h01, 1, 4'd7, 8'h02);
    lit("same_wb", 1'b1, 4'd7, 8'h01, 1'b1, 1'b0);
    cyc(0, 4'd0, 8'd0, 0, 4'd0, 8'd0);
    lit("same_aux", 1'b1, 4'd7, 8'h02, 1'b1, 1'b0);
    cyc(0, 4'd0, 8'd0, 0, 4'd0, 8'd0);

    // Back-to-back aux with writeback idle: one write per cycle
    cyc(0, 4'd0, 8'd0, 1, 4'd11, 8'hB1);
    cyc(0, 4'd0, 8'd0, 1, 4'd12, 8'hB2);
    lit("b2b_1", 1'b1, 4'd11, 8'hB1, 1'b1, 1'b0);
    cyc(0, 4'd0, 8'd0, 0, 4'd0, 8'd0);
    lit("b2b_2", 1'b1, 4'd12, 8'hB2, 1'b1, 1'b0);
    cyc(0, 4'd0, 8'd0, 0, 4'd0, 8'd0);

    // Starvation: one pending aux, writeback held busy
    cyc(0, 4'd0, 8'd0, 1, 4'd4, 8'h44);
    for (int i = 1; i <= 7; i++) cyc(1, 4'd12, 8'(i), 0, 4'd0, 8'd0);
    lit("starve_7", 1'b1, 4'd12, 8'd7, 1'b1, 1'b0);
    cyc(1, 4'd12, 8'd8, 0, 4'd0, 8'd0);
    lit("starve_8", 1'b1, 4'd12, 8'd8, 1'b1, GUARD);
    cyc(1, 4'd12, 8'd9, 0, 4'd0, 8'd0);
    lit("starve_9", 1'b1, 4'd12, 8'd9, 1'b1, GUARD);
    cyc(0, 4'd0, 8'd0, 0, 4'd0, 8'd0);
    lit("starve_grant", 1'b1, 4'd4, 8'h44, 1'b1, 1'b0);
    cyc(0, 4'd0, 8'd0, 0, 4'd0, 8'd0);

    // Reset mid-write with aux contents pending
    cyc(1, 4'd2, 8'h55, 1, 4'd6, 8'h66);
    cyc(1, 4'd3, 8'h56, 1, 4'd6, 8'h67);
    rst_n = 1'b0;
    #1;
    check("midrst_addr", int'(rf_addr), 0);
    check("midrst_data", int'(rf_wdata), 0);
    lit("midrst", 1'b0, 4'd0, 8'd0, 1'b1, 1'b0);
    writeReg_w = 1'b0; aux_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(0, 4'd0, 8'd0, 0, 4'd0, 8'd0);
    lit("post_rst", 1'b0, 4'd0, 8'd0, 1'b1, 1'b0);
    cyc(0, 4'd0, 8'd0, 0, 4'd0, 8'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
